// File: rtl/control_unit.sv
// Hardwired microsequencer: fetches via PC/MAR/MDR/IR and executes ALU, unary and
// MUL/DIV instructions as fixed T-state sequences, with memory wait, stop/run and HALT.
module control_unit #(
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic [15:0] rin,
    output logic [15:0] rout,
    output logic        PCin,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZHIin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [12:0] alu_op,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_PAUSE, S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        C_BIN, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t           state_q, state_d;
    logic             wait_q, wait_d;
    logic [OPW-1:0]   op_s;
    logic [3:0]       ra_s, rb_s, rc_s;
    cls_t             cls_s;
    logic [12:0]      alu_s;
    state_t           last_next_s;
    logic             ir_unused_s;

    function automatic logic [15:0] one_hot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    function automatic cls_t op_class(input logic [OPW-1:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: return C_BIN;
            5'b01111, 5'b10000:                      return C_MULDIV;
            5'b10001, 5'b10010:                      return C_UNARY;
            5'b11010:                                return C_NOP;
            5'b11011:                                return C_HALT;
            default:                                 return C_ILL;
        endcase
    endfunction

    // Bit order 12..0 = ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV
    function automatic logic [12:0] alu_sel(input logic [OPW-1:0] op);
        case (op)
            5'b00011: return 13'h1000;
            5'b00100: return 13'h0800;
            5'b01010: return 13'h0400;
            5'b01011: return 13'h0200;
            5'b00101: return 13'h0100;
            5'b00110: return 13'h0080;
            5'b00111: return 13'h0040;
            5'b01000: return 13'h0020;
            5'b01001: return 13'h0010;
            5'b10001: return 13'h0008;
            5'b10010: return 13'h0004;
            5'b01111: return 13'h0002;
            5'b10000: return 13'h0001;
            default:  return 13'h0000;
        endcase
    endfunction

    assign op_s        = ir[31 -: OPW];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign cls_s       = op_class(op_s);
    assign alu_s       = alu_sel(op_s);
    assign last_next_s = stop ? S_PAUSE : S_T0;
    assign ir_unused_s = ^ir[14:0];

    // State and T1-wait flag register; clr aborts any sequence back to T0
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_T0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_d  = state_q;
        wait_d   = 1'b0;
        rin      = 16'h0000;
        rout     = 16'h0000;
        PCin     = 1'b0;
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZHIin    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = 13'h0000;
        run      = 1'b1;
        illegal  = 1'b0;
        case (state_q)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                // The incremented PC is loaded once, not again on every wait cycle
                PCin    = ~wait_q;
                if (mem_ready) begin
                    MDRin   = 1'b1;
                    state_d = S_T2;
                end else begin
                    wait_d  = 1'b1;
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                case (cls_s)
                    C_BIN: begin
                        rout    = one_hot16(rb_s);
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_MULDIV: begin
                        rout    = one_hot16(ra_s);
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_UNARY: begin
                        rout    = one_hot16(rb_s);
                        alu_op  = alu_s;
                        Zin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_HALT:  state_d = S_HALTED;
                    C_ILL: begin
                        illegal = 1'b1;
                        state_d = last_next_s;
                    end
                    default: state_d = last_next_s;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    C_BIN: begin
                        rout    = one_hot16(rc_s);
                        alu_op  = alu_s;
                        Zin     = 1'b1;
                        state_d = S_T5;
                    end
                    C_MULDIV: begin
                        rout    = one_hot16(rb_s);
                        alu_op  = alu_s;
                        Zin     = 1'b1;
                        ZHIin   = 1'b1;
                        state_d = S_T5;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        rin     = one_hot16(ra_s);
                        state_d = last_next_s;
                    end
                    default: state_d = last_next_s;
                endcase
            end
            S_T5: begin
                case (cls_s)
                    C_BIN: begin
                        Zlowout = 1'b1;
                        rin     = one_hot16(ra_s);
                        state_d = last_next_s;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        state_d = S_T6;
                    end
                    default: state_d = last_next_s;
                endcase
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = last_next_s;
            end
            S_PAUSE: begin
                run     = 1'b0;
                state_d = stop ? S_PAUSE : S_T0;
            end
            S_HALTED: begin
                run     = 1'b0;
                state_d = S_HALTED;
            end
            default: state_d = S_T0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected strobe vectors are queued with
// their stimulus, then each cycle is driven and the DUT outputs compared against them.
module tb_control_unit;

    localparam logic [14:0] P_PCIN   = 15'h4000;
    localparam logic [14:0] P_PCOUT  = 15'h2000;
    localparam logic [14:0] P_INCPC  = 15'h1000;
    localparam logic [14:0] P_MARIN  = 15'h0800;
    localparam logic [14:0] P_MDRIN  = 15'h0400;
    localparam logic [14:0] P_MDROUT = 15'h0200;
    localparam logic [14:0] P_READ   = 15'h0100;
    localparam logic [14:0] P_IRIN   = 15'h0080;
    localparam logic [14:0] P_YIN    = 15'h0040;
    localparam logic [14:0] P_ZIN    = 15'h0020;
    localparam logic [14:0] P_ZHIIN  = 15'h0010;
    localparam logic [14:0] P_ZLOW   = 15'h0008;
    localparam logic [14:0] P_ZHIGH  = 15'h0004;
    localparam logic [14:0] P_HIIN   = 15'h0002;
    localparam logic [14:0] P_LOIN   = 15'h0001;
    localparam logic [15:0] Z16 = 16'h0000;
    localparam logic [14:0] Z15 = 15'h0000;
    localparam logic [12:0] Z13 = 13'h0000;
    localparam logic [61:0] T0_EXP = {Z16, Z16, P_PCOUT | P_MARIN | P_INCPC | P_ZIN, Z13, 1'b1, 1'b0};

    typedef struct packed {
        logic        mr;
        logic        stp;
        logic        cl;
        logic [31:0] irv;
        logic [61:0] exp;
    } rec_t;

    logic        clk = 1'b0;
    logic        clr, mem_ready, stop;
    logic [31:0] ir;
    logic [15:0] rin, rout;
    logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, ZHIin;
    logic        Zlowout, Zhighout, HIin, LOin, run, illegal;
    logic [12:0] alu_op;

    int   errors = 0;
    int   checks = 0;
    bit   armed  = 1'b0;
    int   drv_cnt;
    rec_t sb[$];

    control_unit #(.OPW(5)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .rin(rin), .rout(rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZHIin(ZHIin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus contention: at most one driver on the shared bus each cycle
    always @(negedge clk) begin
        if (armed) begin
            drv_cnt = $countones(rout) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
            checks++;
            if (drv_cnt > 1) begin
                errors++;
                $display("FAIL bus_contention drivers=%0d required<=1 rout=%h", drv_cnt, rout);
            end
        end
    end

    function automatic logic [61:0] dut_vec();
        return {rin, rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
                ZHIin, Zlowout, Zhighout, HIin, LOin, alu_op, run, illegal};
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0000};
    endfunction

    task automatic push(input logic mr, input logic stp, input logic cl, input logic [31:0] irv,
                        input logic [15:0] rin_e, input logic [15:0] rout_e, input logic [14:0] str_e,
                        input logic [12:0] alu_e, input logic run_e, input logic ill_e);
        rec_t r;
        r.mr  = mr;
        r.stp = stp;
        r.cl  = cl;
        r.irv = irv;
        r.exp = {rin_e, rout_e, str_e, alu_e, run_e, ill_e};
        sb.push_back(r);
    endtask

    // Expected cycle sequence of one instruction, built from the opcode map
    task automatic push_instr(input logic [31:0] irv, input int waits, input bit stop_t4,
                              input bit clr_t4, input int halt_cycles);
        logic [4:0]  op;
        logic [15:0] a, b, c;
        logic [12:0] alu;
        int          kind;
        op   = irv[31:27];
        a    = 16'h0001 << irv[26:23];
        b    = 16'h0001 << irv[22:19];
        c    = 16'h0001 << irv[18:15];
        alu  = Z13;
        kind = 5;
        case (op)
            5'b00011: begin kind = 0; alu = 13'h1000; end
            5'b00100: begin kind = 0; alu = 13'h0800; end
            5'b01010: begin kind = 0; alu = 13'h0400; end
            5'b01011: begin kind = 0; alu = 13'h0200; end
            5'b00101: begin kind = 0; alu = 13'h0100; end
            5'b00110: begin kind = 0; alu = 13'h0080; end
            5'b00111: begin kind = 0; alu = 13'h0040; end
            5'b01000: begin kind = 0; alu = 13'h0020; end
            5'b01001: begin kind = 0; alu = 13'h0010; end
            5'b10001: begin kind = 2; alu = 13'h0008; end
            5'b10010: begin kind = 2; alu = 13'h0004; end
            5'b01111: begin kind = 1; alu = 13'h0002; end
            5'b10000: begin kind = 1; alu = 13'h0001; end
            5'b11010: kind = 3;
            5'b11011: kind = 4;
            default:  kind = 5;
        endcase
        push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, P_PCOUT | P_MARIN | P_INCPC | P_ZIN, Z13, 1'b1, 1'b0);
        for (int w = 0; w < waits; w++)
            push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, P_ZLOW | P_READ | ((w == 0) ? P_PCIN : Z15), Z13, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, irv, Z16, Z16, P_ZLOW | P_READ | P_MDRIN | ((waits == 0) ? P_PCIN : Z15), Z13, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, P_MDROUT | P_IRIN, Z13, 1'b1, 1'b0);
        case (kind)
            0: begin
                push(1'b0, 1'b0, 1'b0, irv, Z16, b, P_YIN, Z13, 1'b1, 1'b0);
                push(1'b0, stop_t4, clr_t4, irv, Z16, c, P_ZIN, alu, 1'b1, 1'b0);
                if (!clr_t4) push(1'b0, stop_t4, 1'b0, irv, a, Z16, P_ZLOW, Z13, 1'b1, 1'b0);
            end
            1: begin
                push(1'b0, 1'b0, 1'b0, irv, Z16, a, P_YIN, Z13, 1'b1, 1'b0);
                push(1'b0, 1'b0, 1'b0, irv, Z16, b, P_ZIN | P_ZHIIN, alu, 1'b1, 1'b0);
                push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, P_ZLOW | P_LOIN, Z13, 1'b1, 1'b0);
                push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, P_ZHIGH | P_HIIN, Z13, 1'b1, 1'b0);
            end
            2: begin
                push(1'b0, 1'b0, 1'b0, irv, Z16, b, P_ZIN, alu, 1'b1, 1'b0);
                push(1'b0, 1'b0, 1'b0, irv, a, Z16, P_ZLOW, Z13, 1'b1, 1'b0);
            end
            3, 4:    push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, Z15, Z13, 1'b1, 1'b0);
            default: push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, Z15, Z13, 1'b1, 1'b1);
        endcase
        if (stop_t4 && !clr_t4) begin
            for (int p = 0; p < 3; p++) push(1'b0, 1'b1, 1'b0, irv, Z16, Z16, Z15, Z13, 1'b0, 1'b0);
            push(1'b0, 1'b0, 1'b0, irv, Z16, Z16, Z15, Z13, 1'b0, 1'b0);
        end
        for (int h = 0; h < halt_cycles; h++)
            push(1'b0, 1'b0, (h == halt_cycles - 1), irv, Z16, Z16, Z15, Z13, 1'b0, 1'b0);
    endtask

    task automatic drive_cycle(input rec_t r, output logic [61:0] obs);
        mem_ready = r.mr;
        stop      = r.stp;
        clr       = r.cl;
        ir        = r.irv;
        @(negedge clk);
        obs = dut_vec();
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [61:0] obs;
        clr = 1'b1; mem_ready = 1'b0; stop = 1'b0; ir = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        clr   = 1'b0;
        armed = 1'b1;
        obs = dut_vec();
        checks++;
        if (obs !== T0_EXP) begin errors++; $display("FAIL reset_t0 got=%h want=%h", obs, T0_EXP); end
        checks++;
        if (run !== 1'b1) begin errors++; $display("FAIL reset_run got=%b want=1", run); end
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    endtask

    task automatic test_add();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(32'h1891_8000, 0, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL add cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_mul();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(32'h7988_0000, 0, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL mul cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_mem_wait();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(32'h1891_8000, 3, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL mem_wait cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_neg_illegal();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(mk(5'b10001, 4'd4, 4'd5, 4'd0), 0, 1'b0, 1'b0, 0);
        push_instr(mk(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1'b0, 0);
        push_instr(mk(5'b00000, 4'd6, 4'd7, 4'd8), 0, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL neg_illegal cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_stop();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(mk(5'b00011, 4'd9, 4'd10, 4'd11), 0, 1'b1, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL stop_pause cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_halt();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(32'hD800_0000, 0, 1'b0, 1'b0, 22);
        push_instr(32'h1891_8000, 1, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL halt cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_clr_abort();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(mk(5'b00011, 4'd12, 4'd13, 4'd14), 0, 1'b0, 1'b1, 0);
        push_instr(mk(5'b00100, 4'd5, 4'd6, 4'd7), 0, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL clr_abort cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t e; logic [61:0] obs; int n = 0;
        push_instr(mk(5'b10000, 4'd2, 4'd9, 4'd0), 0, 1'b0, 1'b0, 0);
        push_instr(mk(5'b10010, 4'd10, 4'd11, 4'd0), 2, 1'b0, 1'b0, 0);
        push_instr(mk(5'b11010, 4'd1, 4'd1, 4'd1), 0, 1'b0, 1'b0, 0);
        push_instr(mk(5'b01001, 4'd15, 4'd0, 4'd14), 0, 1'b0, 1'b0, 0);
        push_instr(mk(5'b00110, 4'd7, 4'd8, 4'd6), 1, 1'b0, 1'b0, 0);
        push_instr(mk(5'b01011, 4'd3, 4'd4, 4'd5), 0, 1'b0, 1'b0, 0);
        push_instr(mk(5'b00101, 4'd0, 4'd15, 4'd1), 0, 1'b0, 1'b0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); drive_cycle(e, obs); checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", n, obs, e.exp); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_mem_wait();
        test_neg_illegal();
        test_stop();
        test_halt();
        test_clr_abort();
        test_back_to_back();
        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired microsequencer that drives the datapath's register-transfer control strobes. It fetches each instruction through PC/MAR/MDR/IR and executes register-register ALU, unary and MUL/DIV instructions as fixed T-state sequences. It also handles the memory read handshake, stop/run and HALT. It sits beside the datapath, reads the IR contents back, and owns every `*in`/`*out` strobe plus the one-hot ALU op lines.

## Interface
Parameters:
- `OPW`, 5: opcode width, taken from `ir[31:27]`.

Ports:
- `clk`  in  1: system clock, rising edge.
- `clr`  in  1: synchronous, active-high reset.
- `ir`  in  32: current IR value. Fields: op=`[31:27]`, Ra=`[26:23]`, Rb=`[22:19]`, Rc=`[18:15]`.
- `mem_ready`  in  1: memory read data is valid on MDatain.
- `stop`  in  1: pause request, sampled only at instruction boundary.
- `rin`  out  16: one-hot register write enables; bit n drives Rn-in.
- `rout`  out  16: one-hot register bus drives; bit n drives Rn-out.
- `PCin, PCout, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, ZHIin, Zlowout, Zhighout, HIin, LOin`  out  1 each: datapath strobes.
- `alu_op`  out  13: one-hot ALU select. Bit order 12..0 = ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV.
- `run`  out  1: high while sequencing; low in PAUSE or HALTED.
- `illegal`  out  1: one-cycle pulse when an undefined opcode is decoded.

## Operation
- States: T0, T1, T2, T3, T4, T5, T6, PAUSE, HALTED. All strobes decode combinationally from state, the opcode and the register fields (Moore outputs). Any strobe not listed for a state is 0.
- T0: `PCout`, `MARin`, `IncPC`, `Zin`. Next state is T1.
- T1: `Zlowout`, `PCin`, `Read`.
  - If `mem_ready` is 0: hold T1 with `Read` held high; `PCin` is asserted only on the first T1 cycle.
  - If `mem_ready` is 1: also assert `MDRin`, then go to T2.
- T2: `MDRout`, `IRin`. Next state is T3.
- Opcode map:
  - Binary: ADD=00011, SUB=00100, SHR=00101, SHRA=00110, SHL=00111, ROR=01000, ROL=01001, AND=01010, OR=01011.
  - MUL=01111, DIV=10000.
  - Unary: NEG=10001, NOT=10010.
  - NOP=11010, HALT=11011.
- Binary ops:
  - T3: `rout[Rb]`, `Yin`.
  - T4: `rout[Rc]`, `alu_op`, `Zin`.
  - T5: `Zlowout`, `rin[Ra]`. Next state is T0.
- MUL/DIV:
  - T3: `rout[Ra]`, `Yin`.
  - T4: `rout[Rb]`, `alu_op`, `Zin`, `ZHIin`.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`. Next state is T0.
- NEG/NOT:
  - T3: `rout[Rb]`, `alu_op`, `Zin`.
  - T4: `Zlowout`, `rin[Ra]`. Next state is T0.
- NOP: T3 asserts nothing. Next state is T0.
- Undefined opcode: behaves as NOP and pulses `illegal` in T3.
- HALT: T3 goes to HALTED. HALTED holds all strobes at 0 and `run`=0, and is left only by `clr`.
- Stop/run: leaving the last T-state of an instruction, if `stop`=1, go to PAUSE instead of T0. PAUSE has all strobes 0 and `run`=0. It returns to T0 on the first cycle with `stop`=0. `stop` has no effect mid-instruction.
- At most one `rout` bit and one bus-out strobe are high in any cycle. Bus contention is a design error and is asserted in simulation.

## Timing
- `clr` sampled high: state becomes T0 on that edge. All outputs are 0 during and after the reset cycle except those T0 asserts. `run`=1 and `illegal`=0.
- `clr` mid-instruction, including during T1 wait: abort immediately, no further strobes, restart at T0.
- `clr` has priority over `mem_ready`, `stop` and HALT.
- Strobes are valid throughout the state cycle. Datapath registers capture at the rising edge that ends the state.
- `ir` is used only from T3 onward, one cycle after the `IRin` edge.
- Cycle counts with zero-wait memory (`mem_ready`=1 in first T1): binary 6, MUL/DIV 7, NEG/NOT 5, NOP 4. Each wait cycle adds 1.

## Test plan
- Reset, then fetch ADD R1,R2,R3 (0x18918000) with `mem_ready`=1:
  - T0..T5 occupy 6 cycles.
  - T3 `rout`=0x0004 with `Yin`.
  - T4 `rout`=0x0008 with `alu_op`=0x1000.
  - T5 `rin`=0x0002; next state is T0.
- MUL R3,R1 (0x79880000): T4 asserts `Zin`+`ZHIin` with `alu_op`=0x0002; T5 `LOin`; T6 `HIin`; 7 cycles total.
- `mem_ready` low for 3 cycles in T1:
  - `Read` stays high for 4 cycles.
  - `PCin` is high only in the first T1 cycle.
  - `MDRin` is high only in the ready cycle.
  - Total instruction is 9 cycles.
- NEG R4,R5 followed by opcode 11111:
  - NEG completes in 5 cycles with `rin`=0x0010.
  - The next instruction pulses `illegal` for 1 cycle, and `rin` stays 0.
- `stop`=1 during an ADD's T4: the ADD completes T5, enters PAUSE with `run`=0, and resumes at T0 the cycle after `stop` drops.
- HALT (0xD8000000): HALTED after T3, with `run`=0 for 20+ cycles. `clr` pulse returns to T0 with `run`=1. Separately, `clr` asserted in T4 of ADD gives T0 next cycle with no `rin` write.
